tx_crc_serializer: RTL and testbench

//  Consumes the 136-bit packet image built by the TX input register and transmits it serially, MSB first.

---
 rtl/tx_crc_serializer_pkg.sv | 53 +++++
 rtl/tx_crc_serializer_if.sv | 39 +++
 rtl/tx_crc_serializer_crc8_bit_update.sv | 24 ++
 rtl/tx_crc_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_tx_crc_serializer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_crc_serializer_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the TX CRC serializer: FSM state encoding, packet
// image geometry, header field offsets and default CRC/preamble constants.
// -----------------------------------------------------------------------------
package tx_pkg;

  // Packet image geometry
  localparam int unsigned PKT_W     = 136;
  localparam int unsigned PAY_W     = 128;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned CRC_W     = 8;

  // Header field offsets inside the packet image
  localparam int unsigned DEST_MSB = 135;
  localparam int unsigned DEST_LSB = 134;
  localparam int unsigned SRC_MSB  = 133;
  localparam int unsigned SRC_LSB  = 132;
  localparam int unsigned LEN_MSB  = 131;
  localparam int unsigned LEN_LSB  = 128;

  // Default CRC / preamble constants
  localparam logic [CRC_W-1:0]  CRC_POLY_DFLT = 8'h07;
  localparam logic [CRC_W-1:0]  CRC_INIT_DFLT = 8'h00;
  localparam logic [BYTE_W-1:0] PREAMBLE_DFLT = 8'hAA;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    CRC  = 3'd4
  } state_e;

  // Header byte as transmitted, MSB first
  typedef struct packed {
    logic [1:0]       dest;
    logic [1:0]       src;
    logic [LEN_W-1:0] len;
  } hdr_t;

  // Extract the header fields from a packet image
  function automatic hdr_t hdr_of(input logic [PKT_W-1:0] pkt);
    hdr_t h;
    h.dest = pkt[DEST_MSB:DEST_LSB];
    h.src  = pkt[SRC_MSB:SRC_LSB];
    h.len  = pkt[LEN_MSB:LEN_LSB];
    return h;
  endfunction

endpackage

// File: rtl/tx_crc_serializer_if.sv
// -----------------------------------------------------------------------------
// tx_crc_serializer_if
// Bundles the serializer's request/flag inputs and serial/status outputs.
//   master : TX input register / link side (drives start, packet, flags)
//   slave  : the serializer (drives serial line and status)
// Signals:
//   start, tx_packet[135:0], test_mode, header_ready, data_ready   (to slave)
//   tx_serial, tx_valid, tx_sof, tx_eof, busy, done, start_err,
//   crc_out[7:0]                                                   (from slave)
// -----------------------------------------------------------------------------
interface tx_crc_serializer_if;
  import tx_pkg::*;

  logic                 start;
  logic [PKT_W-1:0]     tx_packet;
  logic                 test_mode;
  logic                 header_ready;
  logic                 data_ready;

  logic                 tx_serial;
  logic                 tx_valid;
  logic                 tx_sof;
  logic                 tx_eof;
  logic                 busy;
  logic                 done;
  logic                 start_err;
  logic [CRC_W-1:0]     crc_out;

  modport master (
    output start, tx_packet, test_mode, header_ready, data_ready,
    input  tx_serial, tx_valid, tx_sof, tx_eof, busy, done, start_err, crc_out
  );

  modport slave (
    input  start, tx_packet, test_mode, header_ready, data_ready,
    output tx_serial, tx_valid, tx_sof, tx_eof, busy, done, start_err, crc_out
  );

endinterface

// File: rtl/tx_crc_serializer_crc8_bit_update.sv
// -----------------------------------------------------------------------------
// crc8_bit_update
// Combinational single-bit CRC-8 step (MSB-first, implicit x^8 term).
// Ports:
//   crc_in[7:0]  current CRC register
//   bit_in       data bit entering the CRC
//   crc_out[7:0] CRC register after absorbing bit_in
// Parameter:
//   POLY         generator polynomial without the x^8 term
// -----------------------------------------------------------------------------
module crc8_bit_update #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  logic fb;

  assign fb      = crc_in[7] ^ bit_in;
  assign crc_out = {crc_in[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

endmodule

// File: rtl/tx_crc_serializer.sv
// -----------------------------------------------------------------------------
// tx_crc_serializer
// Serializes a latched 136-bit packet image MSB first as
//   [preamble] header, len payload bytes, CRC-8
// computing the CRC on the fly over header and payload bits. test_mode
// inverts bit0 of the CRC on the line only; crc_out keeps the clean value.
// Optional feature: define TX_PREAMBLE_EN to send PREAMBLE before the header.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   tx_crc_serializer_if.slave (start/packet/flags in, serial/status out)
// Parameters:
//   CRC_POLY, CRC_INIT, PREAMBLE
// -----------------------------------------------------------------------------
module tx_crc_serializer
  import tx_pkg::*;
#(
  parameter logic [CRC_W-1:0]  CRC_POLY = CRC_POLY_DFLT,
  parameter logic [CRC_W-1:0]  CRC_INIT = CRC_INIT_DFLT,
  parameter logic [BYTE_W-1:0] PREAMBLE = PREAMBLE_DFLT
) (
  input logic                clk,
  input logic                rst,
  tx_crc_serializer_if.slave bus
);

  // FSM and datapath state
  state_e                 state_q,    state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [LEN_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [PKT_W-1:0]       pkt_q,      pkt_d;
  logic                   tm_q,       tm_d;
  logic [CRC_W-1:0]       crc_q,      crc_d;
  logic [CRC_W-1:0]       crc_out_q,  crc_out_d;

  // Registered outputs
  logic serial_q,    serial_d;
  logic valid_q,     valid_d;
  logic sof_q,       sof_d;
  logic eof_q,       eof_d;
  logic busy_q,      busy_d;
  logic done_q,      done_d;
  logic start_err_q, start_err_d;

  logic [CRC_W-1:0] crc_step_c;
  logic             data_bit_c;
  logic [LEN_W-1:0] len_lat_c;
  logic [LEN_W-1:0] len_in_c;

  // Bit on the line for a given FSM position; shared by the current-bit
  // (CRC feed) and next-bit (output register) paths so they cannot diverge
  function automatic logic line_bit(
    input state_e               st,
    input logic [BIT_CNT_W-1:0] bc,
    input logic [LEN_W-1:0]     byc,
    input logic [PKT_W-1:0]     pkt,
    input logic [CRC_W-1:0]     crc,
    input logic                 tm
  );
    logic [PAY_W-1:0]  pay_sh;
    logic [BYTE_W-1:0] pay_byte;
    logic [BYTE_W-1:0] hdr_byte;
    pay_sh   = pkt[PAY_W-1:0] << {byc, 3'b000};
    pay_byte = pay_sh[PAY_W-1 -: BYTE_W];
    hdr_byte = hdr_of(pkt);
    case (st)
      PRE:     line_bit = PREAMBLE[bc];
      HDR:     line_bit = hdr_byte[bc];
      PAY:     line_bit = pay_byte[bc];
      CRC:     line_bit = crc[bc] ^ ((bc == 3'd0) & tm);
      default: line_bit = 1'b0;
    endcase
  endfunction

  assign len_lat_c  = hdr_of(pkt_q).len;
  assign len_in_c   = hdr_of(bus.tx_packet).len;
  assign data_bit_c = line_bit(state_q, bit_cnt_q, byte_cnt_q, pkt_q, crc_q, tm_q);

  // One-bit CRC step over the bit currently on the line
  crc8_bit_update #(
    .POLY (CRC_POLY)
  ) u_crc8 (
    .crc_in  (crc_q),
    .bit_in  (data_bit_c),
    .crc_out (crc_step_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    pkt_d       = pkt_q;
    tm_d        = tm_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    sof_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.header_ready && (bus.data_ready || (len_in_c == 4'd0))) begin
            pkt_d      = bus.tx_packet;
            tm_d       = bus.test_mode;
            crc_d      = CRC_INIT;
            bit_cnt_d  = 3'd7;
            byte_cnt_d = 4'd0;
            sof_d      = 1'b1;
`ifdef TX_PREAMBLE_EN
            state_d    = PRE;
`else
            state_d    = HDR;
`endif
          end else begin
            start_err_d = 1'b1;
          end
        end
      end

      PRE: begin
        if (bit_cnt_q == 3'd0) begin
          state_d   = HDR;
          bit_cnt_d = 3'd7;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end

      HDR: begin
        crc_d = crc_step_c;
        if (bit_cnt_q == 3'd0) begin
          bit_cnt_d  = 3'd7;
          byte_cnt_d = 4'd0;
          state_d    = (len_lat_c == 4'd0) ? CRC : PAY;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end

      PAY: begin
        crc_d = crc_step_c;
        if (bit_cnt_q == 3'd0) begin
          bit_cnt_d = 3'd7;
          if (byte_cnt_q == (len_lat_c - 4'd1)) begin
            state_d = CRC;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end

      CRC: begin
        // CRC register is frozen here; only the line copy carries test_mode
        if (bit_cnt_q == 3'd0) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          crc_out_d = crc_q;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs describe the bit that will be on the line next cycle
    valid_d  = (state_d != IDLE);
    busy_d   = valid_d;
    eof_d    = (state_d == CRC) && (bit_cnt_d == 3'd0);
    serial_d = valid_d ? line_bit(state_d, bit_cnt_d, byte_cnt_d, pkt_d, crc_d, tm_d)
                       : 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      pkt_q       <= '0;
      tm_q        <= 1'b0;
      crc_q       <= '0;
      crc_out_q   <= '0;
      serial_q    <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pkt_q       <= pkt_d;
      tm_q        <= tm_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      serial_q    <= serial_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

  assign bus.tx_serial = serial_q;
  assign bus.tx_valid  = valid_q;
  assign bus.tx_sof    = sof_q;
  assign bus.tx_eof    = eof_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.start_err = start_err_q;
  assign bus.crc_out   = crc_out_q;

endmodule

// File: tb/tb_tx_crc_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_crc_serializer
// Directed, self-checking bench for tx_crc_serializer. Expected line bits are
// queued from an independent byte-wise CRC model when a frame is started and
// popped as the DUT drives tx_valid.
// -----------------------------------------------------------------------------
module tb_tx_crc_serializer;
  import tx_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tx_crc_serializer_if bus ();

  tx_crc_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic        exp_q[$];
  logic [7:0]  exp_crc;
  int unsigned exp_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Byte-wise CRC-8, poly 0x07, init 0x00
  function automatic logic [7:0] model_crc(input logic [7:0] bytes[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (bytes[i]) begin
      c = c ^ bytes[i];
      for (int k = 0; k < 8; k++) begin
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
  endtask

  task automatic push_frame(input logic [7:0] hdr, input logic [127:0] pay, input logic tm);
    logic [7:0]   bytes[$];
    logic [127:0] sh;
    int           len;
    len = int'(hdr[3:0]);
    bytes.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      sh = pay << (8 * i);
      bytes.push_back(sh[127:120]);
    end
    exp_crc = model_crc(bytes);
`ifdef TX_PREAMBLE_EN
    push_byte(8'hAA);
`endif
    foreach (bytes[i]) push_byte(bytes[i]);
    push_byte(exp_crc ^ {7'b0, tm});
    exp_bits = exp_q.size();
  endtask

  // Called right after a negedge: queue the model and raise start
  task automatic start_frame(input logic [7:0] hdr, input logic [127:0] pay, input logic tm,
                             input logic hr, input logic dr);
    push_frame(hdr, pay, tm);
    bus.tx_packet    = {hdr, pay};
    bus.test_mode    = tm;
    bus.header_ready = hr;
    bus.data_ready   = dr;
    bus.start        = 1'b1;
  endtask

  // Follow one frame until the done cycle; returns sitting on that negedge
  task automatic run_frame(input string tag);
    int  cyc;
    int  idx;
    bit  fin;
    logic b;
    cyc = 0;
    idx = 0;
    fin = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_valid) begin
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check({tag, " bit"}, 32'(bus.tx_serial), 32'(b));
          check({tag, " sof"}, 32'(bus.tx_sof), 32'(idx == 0));
          check({tag, " eof"}, 32'(bus.tx_eof), 32'(exp_q.size() == 0));
          check({tag, " busy"}, 32'(bus.busy), 32'd1);
        end
        idx++;
      end else if (bus.done) begin
        check({tag, " bit count"}, 32'(idx), 32'(exp_bits));
        check({tag, " done latency"}, 32'(cyc), 32'(exp_bits + 1));
        check({tag, " done busy"}, 32'(bus.busy), 32'd0);
        check({tag, " idle line"}, 32'(bus.tx_serial), 32'd0);
        check({tag, " crc_out"}, 32'(bus.crc_out), 32'(exp_crc));
        fin = 1'b1;
      end
      // Scramble inputs after the accept edge; the frame must use the latch
      if (cyc == 1) begin
        bus.start     = 1'b0;
        bus.tx_packet = ~bus.tx_packet;
        bus.test_mode = ~bus.test_mode;
      end
    end
    check({tag, " finished"}, 32'(fin), 32'd1);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tx_serial"}, 32'(bus.tx_serial), 32'd0);
    check({tag, " tx_valid"},  32'(bus.tx_valid),  32'd0);
    check({tag, " tx_sof"},    32'(bus.tx_sof),    32'd0);
    check({tag, " tx_eof"},    32'(bus.tx_eof),    32'd0);
    check({tag, " busy"},      32'(bus.busy),      32'd0);
    check({tag, " done"},      32'(bus.done),      32'd0);
    check({tag, " start_err"}, 32'(bus.start_err), 32'd0);
    check({tag, " crc_out"},   32'(bus.crc_out),   32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.tx_packet    = '0;
    bus.test_mode    = 1'b0;
    bus.header_ready = 1'b0;
    bus.data_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: len 1, payload 0x00
    start_frame(8'h41, 128'h0, 1'b0, 1'b1, 1'b1);
    run_frame("t1");
    check("t1 crc_out const", 32'(bus.crc_out), 32'h4E);
    @(negedge clk);
    check("t1 done pulse width", 32'(bus.done), 32'd0);
    check("t1 crc_out held", 32'(bus.crc_out), 32'h4E);

    // 2: same with CRC corruption on the line
    start_frame(8'h41, 128'h0, 1'b1, 1'b1, 1'b1);
    run_frame("t2");
    check("t2 crc_out clean", 32'(bus.crc_out), 32'h4E);
    @(negedge clk);

    // 3: len 0 accepted without data_ready
    start_frame(8'h40, 128'h0, 1'b0, 1'b1, 1'b0);
    run_frame("t3");
    check("t3 crc_out const", 32'(bus.crc_out), 32'hC7);
    @(negedge clk);

    // 4: rejected starts
    bus.tx_packet    = {8'h41, 128'h0};
    bus.header_ready = 1'b0;
    bus.data_ready   = 1'b1;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4 start_err", 32'(bus.start_err), 32'd1);
    check("t4 busy", 32'(bus.busy), 32'd0);
    check("t4 tx_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    check("t4 start_err pulse", 32'(bus.start_err), 32'd0);
    check("t4 busy later", 32'(bus.busy), 32'd0);
    check("t4 crc_out kept", 32'(bus.crc_out), 32'hC7);
    bus.header_ready = 1'b1;
    bus.data_ready   = 1'b0;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4b start_err", 32'(bus.start_err), 32'd1);
    check("t4b tx_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);

    // 5: reset in the middle of a frame
    start_frame(8'h41, 128'h0, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      check("t5 valid before reset", 32'(bus.tx_valid), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("t5 after reset");
    exp_q.delete();
    repeat (30) begin
      @(negedge clk);
      check("t5 no done", 32'(bus.done), 32'd0);
    end
    start_frame(8'h41, 128'h0, 1'b0, 1'b1, 1'b1);
    run_frame("t5 restart");
    @(negedge clk);

    // 6: max length, then back-to-back start in the done cycle
    start_frame(8'h0F, {128{1'b1}}, 1'b0, 1'b1, 1'b1);
    run_frame("t6a");
    start_frame(8'hC2, {8'h5A, 8'h3C, 112'h0}, 1'b0, 1'b1, 1'b1);
    run_frame("t6b");
    @(negedge clk);
    check("t6 idle after", 32'(bus.tx_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
